inverter_freq_meter: RTL and testbench
======================================

Name: inverter_freq_meter

Overview:
- Digital measurement companion to the analog inverter macro.
- The inverter or ring-oscillator output returns as a digital level on a dedicated input. This block counts its rising edges over a programmable gate window and latches the result.
- It then serialises the result as 8N1 UART on an output pin for bench readout.
- Instantiated inside the Tiny Tapeout top next to the analog macro.

Parameters:
- CNT_W, 16, edge-counter width; must be a multiple of 8.
- GATE_CYCLES, 1000, base gate length in clk cycles; must be at least 1.
- BAUD_DIV, 104, clk cycles per UART bit; must be at least 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design enable; low aborts any operation
- sig_in  input  1  asynchronous inverter output
- start  input  1  level; sampled in IDLE
- gate_sel  input  2  gate length = GATE_CYCLES << (2*gate_sel), captured at start
- count  output  CNT_W  last latched edge count
- valid  output  1  one-cycle pulse when count updates
- overflow  output  1  set if the last measurement saturated
- busy  output  1  high in every state except IDLE
- tx  output  1  UART line, idle high

Behaviour:
- Reset (async assert, sync release): state=IDLE, count=0, valid=0, overflow=0, busy=0, tx=1. Synchroniser flops and all counters are cleared.
- Input conditioning:
  - sig_in passes through a 2-flop synchroniser, then a rising-edge detector (1-cycle pulse).
  - Detect latency is 3 clk from the pin.
  - Input frequency must stay below clk/4 for exact counts; faster input aliases, and no detection is required.
- FSM states: IDLE, GATE, LATCH, TX, WAIT_RELEASE.
  - IDLE: when start=1 and ena=1, capture gate_sel, load gate_cnt=GATE_CYCLES<<(2*gate_sel), clear edge_cnt and the overflow flag, then go to GATE.
  - GATE: exactly gate-length cycles.
    - Each edge pulse asserted during a GATE cycle increments edge_cnt.
    - At all-ones, edge_cnt holds and the internal overflow flag sets.
    - Go to LATCH on the cycle gate_cnt reaches 1.
  - LATCH (1 cycle): count<=edge_cnt and overflow<=flag. valid=1 on the following cycle only. Go to TX.
  - TX: send CNT_W/8 bytes, most-significant byte first.
    - Each byte: start bit 0, 8 data bits LSB first, stop bit 1. Every bit lasts BAUD_DIV cycles.
    - No gap between bytes.
    - Go to WAIT_RELEASE after the final stop bit.
  - WAIT_RELEASE: stay until start=0, then go to IDLE. A held start therefore gives exactly one measurement.
- ena=0 in any state: next state is IDLE, tx=1 on the next cycle, and the UART is aborted mid-frame.
  - count and overflow keep their last values; valid is not pulsed.
  - A measurement aborted during GATE leaves count unchanged.
- start changes outside IDLE/WAIT_RELEASE are ignored, as are gate_sel changes after capture.
- tx is registered (no glitches); it is 1 in every state except during TX frame bits.
- count and overflow are stable outside LATCH+1; they update only at that cycle.

Decomposition:
- Package inverter_meter_pkg holds:
  - FSM state enum.
  - UART frame constants: START_BIT=0, STOP_BIT=1, DATA_BITS=8.
  - A function computing gate length from GATE_CYCLES and gate_sel.
- Sub-module uart_tx_byte:
  - Inputs: clk, rst_n, abort, load, data[7:0].
  - Outputs: tx, done pulse.
  - Contains the baud divider and 10-bit frame shifter.
- The parent sequences the bytes.

Test Plan (bench uses GATE_CYCLES=100, BAUD_DIV=4, CNT_W=16 unless noted):
- Basic count: sig_in period 10 clk (5 high/5 low), pulse start, gate_sel=0 -> valid once; count=10, overflow=0; busy high from cycle after start until WAIT_RELEASE exit.
- Gate select: same input with gate_sel=1 (400 cycles) -> count=40; with gate_sel=2 (1600 cycles) -> count=160.
- Saturation: CNT_W=8 build, sig_in period 4, gate_sel=2 (1600 cycles, 400 edges) -> count=255, overflow=1.
  - Next run with sig_in constant -> count=0, overflow=0.
- UART frame: count=10 -> tx sends byte 0x00 then 0x0A.
  - Bits for 0x0A: 0,0,1,0,1,0,0,0,0,1, each exactly 4 clk.
  - 80 clk total; tx=1 afterwards.
- Abort/reset: rst_n low mid-GATE -> all outputs at reset values immediately, next start runs cleanly.
  - ena low mid-TX -> tx=1 next cycle, state IDLE, count retained, no further frame bits.
- Held start: start held high for 3 measurement durations -> exactly one valid pulse and one UART frame; a second run begins only after start drops and reasserts.

Source files
------------

// File: rtl/inverter_meter_pkg.sv
// Shared types and constants for the inverter frequency meter: FSM states,
// UART framing constants and the gate-length helper.
package inverter_meter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE,
        ST_LATCH,
        ST_TX,
        ST_WAIT_RELEASE
    } meter_state_e;

    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = DATA_BITS + 2;

    // Gate length quadruples per gate_sel step: base << (2*sel).
    function automatic int unsigned gate_len(input int unsigned base, input logic [1:0] sel);
        return base << {sel, 1'b0};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 UART transmitter with a registered line output.
// A load on the done cycle starts the next frame with no idle gap.
module uart_tx_byte
    import inverter_meter_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 104
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 abort,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 done
);

    localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
    localparam int unsigned BIT_W  = $clog2(FRAME_BITS);

    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  active_q, active_d;
    logic                  tx_q, tx_d;
    logic                  tick, last_bit;

    assign tick     = active_q && (baud_q == BAUD_W'(BAUD_DIV - 1));
    assign last_bit = (bit_q == BIT_W'(FRAME_BITS - 1));
    assign done     = tick && last_bit;
    assign tx       = tx_q;

    always_comb begin
        shift_d  = shift_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        active_d = active_q;
        tx_d     = tx_q;
        if (abort) begin
            active_d = 1'b0;
            tx_d     = STOP_BIT;
            baud_d   = '0;
            bit_d    = '0;
        end else if (load && (!active_q || done)) begin
            shift_d  = {STOP_BIT, data, START_BIT};
            tx_d     = START_BIT;
            active_d = 1'b1;
            baud_d   = '0;
            bit_d    = '0;
        end else if (tick) begin
            baud_d = '0;
            if (last_bit) begin
                active_d = 1'b0;
                tx_d     = STOP_BIT;
            end else begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 1'b1;
                tx_d    = shift_q[1];
            end
        end else if (active_q) begin
            baud_d = baud_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '1;
            baud_q   <= '0;
            bit_q    <= '0;
            active_q <= 1'b0;
            tx_q     <= STOP_BIT;
        end else begin
            shift_q  <= shift_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            active_q <= active_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/inverter_freq_meter.sv
// Counts rising edges of the synchronised inverter output over a programmable
// gate window, latches the result and streams it out MSB byte first over UART.
module inverter_freq_meter
    import inverter_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned BAUD_DIV    = 104
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             sig_in,
    input  logic             start,
    input  logic [1:0]       gate_sel,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             overflow,
    output logic             busy,
    output logic             tx
);

    localparam int unsigned NBYTES = CNT_W / DATA_BITS;
    localparam int unsigned GATE_W = $clog2((GATE_CYCLES << 6) + 1);
    localparam int unsigned BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    meter_state_e         state_q, state_d;
    logic [2:0]           sync_q;
    logic                 rise_q;
    logic [GATE_W-1:0]    gate_q, gate_d;
    logic [CNT_W-1:0]     ecnt_q, ecnt_d;
    logic                 flag_q, flag_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 valid_q, valid_d;
    logic [CNT_W-1:0]     word_q, word_d;
    logic [BYTE_W-1:0]    byte_q, byte_d;
    logic                 load;
    logic [DATA_BITS-1:0] ld_data;
    logic                 tx_done;

    // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], sig_in};
            rise_q <= sync_q[1] & ~sync_q[2];
        end
    end

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        ecnt_d  = ecnt_q;
        flag_d  = flag_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        word_d  = word_q;
        byte_d  = byte_q;
        load    = 1'b0;
        ld_data = word_q[CNT_W-1 -: DATA_BITS];
        if (!ena) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        gate_d  = GATE_W'(gate_len(GATE_CYCLES, gate_sel));
                        ecnt_d  = '0;
                        flag_d  = 1'b0;
                        state_d = ST_GATE;
                    end
                end
                ST_GATE: begin
                    if (rise_q) begin
                        if (&ecnt_q) flag_d = 1'b1;
                        else         ecnt_d = ecnt_q + 1'b1;
                    end
                    gate_d = gate_q - 1'b1;
                    if (gate_q == GATE_W'(1)) state_d = ST_LATCH;
                end
                ST_LATCH: begin
                    count_d = ecnt_q;
                    ovf_d   = flag_q;
                    valid_d = 1'b1;
                    load    = 1'b1;
                    ld_data = ecnt_q[CNT_W-1 -: DATA_BITS];
                    word_d  = ecnt_q << DATA_BITS;
                    byte_d  = '0;
                    state_d = ST_TX;
                end
                ST_TX: begin
                    if (tx_done) begin
                        if (byte_q == BYTE_W'(NBYTES - 1)) begin
                            state_d = ST_WAIT_RELEASE;
                        end else begin
                            load   = 1'b1;
                            word_d = word_q << DATA_BITS;
                            byte_d = byte_q + 1'b1;
                        end
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (!start) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gate_q  <= '0;
            ecnt_q  <= '0;
            flag_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            word_q  <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            ecnt_q  <= ecnt_d;
            flag_q  <= flag_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            word_q  <= word_d;
            byte_q  <= byte_d;
        end
    end

    uart_tx_byte #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart (
        .clk  (clk),
        .rst_n(rst_n),
        .abort(~ena),
        .load (load),
        .data (ld_data),
        .tx   (tx),
        .done (tx_done)
    );

    assign count    = count_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_inverter_freq_meter.sv
// Drives a 16-bit and an 8-bit meter with the same periodic input and checks
// counts, saturation, UART frames, aborts and held-start behaviour.
module tb_inverter_freq_meter;

    localparam int unsigned GATE = 100;
    localparam int unsigned BAUD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        sig_in = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  gate_sel = 2'd0;
    logic [15:0] count16;
    logic [7:0]  count8;
    logic        valid16, valid8, ovf16, ovf8, busy16, busy8, tx16, tx8;
    logic [1:0]  tx_w;

    int total = 0;
    int bad   = 0;

    int per = 0;
    int hi  = 0;

    int vcnt16 = 0, vcnt8 = 0, vwide = 0, stab = 0;
    logic        vprev16 = 0, vprev8 = 0;
    logic [15:0] cprev16 = '0;
    logic [7:0]  cprev8 = '0;
    logic        oprev16 = 0, oprev8 = 0;

    logic [15:0] exp16;
    logic [7:0]  exp8;
    logic        ov16, ov8;
    int          v16, v8;

    inverter_freq_meter #(.CNT_W(16), .GATE_CYCLES(GATE), .BAUD_DIV(BAUD)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sig_in(sig_in), .start(start),
        .gate_sel(gate_sel), .count(count16), .valid(valid16), .overflow(ovf16),
        .busy(busy16), .tx(tx16)
    );

    inverter_freq_meter #(.CNT_W(8), .GATE_CYCLES(GATE), .BAUD_DIV(BAUD)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sig_in(sig_in), .start(start),
        .gate_sel(gate_sel), .count(count8), .valid(valid8), .overflow(ovf8),
        .busy(busy8), .tx(tx8)
    );

    assign tx_w = {tx8, tx16};

    always #5 clk = ~clk;

    // Periodic input source: high for hi cycles out of per, changed on negedge.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (per == 0) begin
                sig_in = 1'b0;
                ph = 0;
            end else begin
                if (ph >= per) ph = 0;
                sig_in = (ph < hi);
                ph = (ph + 1 >= per) ? 0 : ph + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (valid16) vcnt16++;
        if (valid8) vcnt8++;
        if ((valid16 && vprev16) || (valid8 && vprev8)) vwide++;
        if (rst_n && !valid16 && (count16 !== cprev16 || ovf16 !== oprev16)) stab++;
        if (rst_n && !valid8 && (count8 !== cprev8 || ovf8 !== oprev8)) stab++;
        vprev16 = valid16; vprev8 = valid8;
        cprev16 = count16; cprev8 = count8;
        oprev16 = ovf16;   oprev8 = ovf8;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input int d, input int nbytes, input logic [15:0] val);
        int t, bad_bits, idx;
        logic e;
        logic [15:0] got;
        t = 0; bad_bits = 0; got = '0;
        while (tx_w[d] !== 1'b0 && t < 200) begin
            cyc();
            t++;
        end
        if (t >= 200) begin
            check_eq($sformatf("frame_start%0d", d), 32'd0, 32'd1);
            return;
        end
        for (int b = 0; b < nbytes; b++) begin
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < int'(BAUD); c++) begin
                    idx = (nbytes - 1 - b) * 8 + k - 1;
                    if (k == 0) e = 1'b0;
                    else if (k == 9) e = 1'b1;
                    else e = val[idx];
                    if (tx_w[d] !== e) bad_bits++;
                    if (c == int'(BAUD / 2) && k >= 1 && k <= 8) got[idx] = tx_w[d];
                    cyc();
                end
            end
        end
        check_eq($sformatf("frame_bits%0d", d), bad_bits, 0);
        check_eq($sformatf("frame_val%0d", d), got, val);
        check_eq($sformatf("tx_idle_after%0d", d), tx_w[d], 1);
    endtask

    task automatic begin_meas(input int sel, input int p, input int h);
        int unsigned L, edges;
        int t;
        per = p; hi = h;
        repeat (8) cyc();
        L = GATE << (2 * sel);
        edges = (p == 0) ? 0 : L / p;
        exp16 = (edges > 65535) ? 16'hFFFF : edges[15:0];
        ov16  = (edges > 65535);
        exp8  = (edges > 255) ? 8'hFF : edges[7:0];
        ov8   = (edges > 255);
        v16 = vcnt16; v8 = vcnt8;
        gate_sel = sel[1:0];
        start = 1'b1;
        cyc();
        check_eq("busy_start16", busy16, 1);
        check_eq("busy_start8", busy8, 1);
        gate_sel = 2'($urandom);
        t = 0;
        while (valid16 !== 1'b1 && t < int'(L) + 20) begin
            cyc();
            t++;
        end
        check_eq("valid16", valid16, 1);
        check_eq("valid8_aligned", valid8, 1);
        check_eq("count16", count16, exp16);
        check_eq("ovf16", ovf16, ov16);
        check_eq("count8", count8, exp8);
        check_eq("ovf8", ovf8, ov8);
    endtask

    task automatic run_meas(input int sel, input int p, input int h, input int hold);
        int errs;
        begin_meas(sel, p, h);
        fork
            check_frame(0, 2, exp16);
            check_frame(1, 1, {8'h00, exp8});
        join
        errs = 0;
        repeat (hold) begin
            cyc();
            if (tx16 !== 1'b1 || tx8 !== 1'b1) errs++;
        end
        check_eq("tx_idle_hold", errs, 0);
        check_eq("busy_hold16", busy16, 1);
        start = 1'b0;
        cyc();
        cyc();
        check_eq("busy_release16", busy16, 0);
        check_eq("busy_release8", busy8, 0);
        check_eq("one_valid16", vcnt16 - v16, 1);
        check_eq("one_valid8", vcnt8 - v8, 1);
    endtask

    initial begin
        int errs, p, keep_v;
        logic [15:0] keep;
        int plist[7] = '{0, 5, 10, 20, 25, 50, 100};

        repeat (3) cyc();
        check_eq("rst_count16", count16, 0);
        check_eq("rst_valid16", valid16, 0);
        check_eq("rst_ovf16", ovf16, 0);
        check_eq("rst_busy16", busy16, 0);
        check_eq("rst_tx16", tx16, 1);
        rst_n = 1'b1;
        repeat (3) cyc();
        check_eq("idle_tx8", tx8, 1);

        run_meas(0, 10, 5, 0);
        run_meas(1, 10, 5, 0);
        run_meas(2, 10, 5, 0);
        run_meas(2, 4, 2, 0);
        run_meas(0, 0, 0, 0);
        run_meas(0, 10, 5, 3 * 200);

        // ena dropped in the middle of the 16-bit frame
        begin_meas(0, 10, 5);
        repeat (5 + $urandom_range(50)) cyc();
        ena = 1'b0;
        cyc();
        check_eq("abort_tx16", tx16, 1);
        check_eq("abort_busy16", busy16, 0);
        check_eq("abort_keep16", count16, exp16);
        errs = 0;
        repeat (60) begin
            cyc();
            if (tx16 !== 1'b1 || tx8 !== 1'b1) errs++;
        end
        check_eq("abort_tx_quiet", errs, 0);
        start = 1'b0;
        cyc();
        ena = 1'b1;
        cyc();
        check_eq("abort_idle16", busy16, 0);
        check_eq("abort_one_valid", vcnt16 - v16, 1);

        // ena dropped during the gate: no result, count retained
        keep = exp16; keep_v = vcnt16;
        per = 25; hi = 10;
        gate_sel = 2'd1;
        start = 1'b1;
        repeat (20 + $urandom_range(200)) cyc();
        ena = 1'b0;
        start = 1'b0;
        repeat (500) cyc();
        check_eq("gate_abort_keep", count16, keep);
        check_eq("gate_abort_novalid", vcnt16 - keep_v, 0);
        check_eq("gate_abort_busy", busy16, 0);
        ena = 1'b1;
        cyc();

        // reset asserted mid-gate after a nonzero result
        run_meas(0, 20, 7, 0);
        gate_sel = 2'd1;
        start = 1'b1;
        repeat (30 + $urandom_range(200)) cyc();
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_count16", count16, 0);
        check_eq("mid_rst_valid16", valid16, 0);
        check_eq("mid_rst_ovf16", ovf16, 0);
        check_eq("mid_rst_busy16", busy16, 0);
        check_eq("mid_rst_busy8", busy8, 0);
        check_eq("mid_rst_tx16", tx16, 1);
        start = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        run_meas(0, 20, 7, 0);

        for (int i = 0; i < 8; i++) begin
            p = plist[$urandom_range(6)];
            run_meas(int'($urandom_range(2)), p, (p == 0) ? 0 : 1 + int'($urandom_range(p - 2)),
                     int'($urandom_range(300)));
        end

        check_eq("valid_width", vwide, 0);
        check_eq("count_stable", stab, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
